// File: rtl/psi_generator_pkg.sv
// Shared definitions for the psi square-wave generator and the regulator it serves.
package psi_generator_pkg;

  localparam int DIV_W_DEF = 8;
  localparam logic [DIV_W_DEF-1:0] DIV_MAX = {DIV_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/psi_generator_phase_counter.sv
// Loadable up-counter timing one psi phase; tc is high while the count sits at all-ones.
module phase_counter
  import psi_generator_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] loadVal,
  input  logic             inc,
  output logic             tc,
  output logic             tcNext
);

  localparam logic [DIV_W-1:0] CNT_MAX = {DIV_W{1'b1}};
  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] cnt_s;

  // Next count: load wins over increment, otherwise hold.
  always_comb begin
    cnt_s = cnt_r;
    if (load) begin
      cnt_s = loadVal;
    end else if (inc) begin
      cnt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_s = cnt_r;
    end
    tcNext = (cnt_s == CNT_MAX);
  end

  // Count and terminal-count registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {DIV_W{1'b0}};
      tc    <= 1'b0;
    end else begin
      cnt_r <= cnt_s;
      tc    <= tcNext;
    end
  end

endmodule

// File: rtl/psi_generator.sv
// Symmetric square-wave generator: each phase lasts 2^DIV_W - curDiv cycles,
// with the divider latched once per period at the psi rise.
module psi_generator
  import psi_generator_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] divLoad,
  output logic             psi,
  output logic [DIV_W-1:0] curDiv,
  output logic             periodDone,
  output logic [DIV_W-1:0] periodCount,
  output logic             busy
);

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic             psi_s;
  logic [DIV_W-1:0] cur_div_s;
  logic [DIV_W-1:0] period_count_s;
  logic             done_s;
  logic             load_s;
  logic             inc_s;
  logic [DIV_W-1:0] load_val_s;
  logic             tc_s;
  logic             tc_next_s;

  phase_counter #(.DIV_W(DIV_W)) u_phase_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .loadVal (load_val_s),
    .inc     (inc_s),
    .tc      (tc_s),
    .tcNext  (tc_next_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_s        = state_r;
    psi_s          = psi;
    cur_div_s      = curDiv;
    period_count_s = periodCount;
    load_s         = 1'b0;
    inc_s          = 1'b0;
    load_val_s     = divLoad;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_s   = ST_HIGH;
          psi_s     = 1'b1;
          cur_div_s = divLoad;
          load_s    = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (tc_s) begin
          state_s    = ST_LOW;
          psi_s      = 1'b0;
          load_s     = 1'b1;
          load_val_s = curDiv;
        end else begin
          inc_s = 1'b1;
        end
      end
      ST_LOW: begin
        if (tc_s) begin
          period_count_s = periodCount + CNT_ONE;
          if (en) begin
            state_s   = ST_HIGH;
            psi_s     = 1'b1;
            cur_div_s = divLoad;
            load_s    = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          inc_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        psi_s   = 1'b0;
      end
    endcase
    // Look ahead so the registered pulse lands on the last LOW cycle itself.
    done_s = (state_s == ST_LOW) && tc_next_s;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      psi         <= 1'b0;
      curDiv      <= {DIV_W{1'b0}};
      periodDone  <= 1'b0;
      periodCount <= {DIV_W{1'b0}};
      busy        <= 1'b0;
    end else begin
      state_r     <= state_s;
      psi         <= psi_s;
      curDiv      <= cur_div_s;
      periodDone  <= done_s;
      periodCount <= period_count_s;
      busy        <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_psi_generator.sv
// Self-checking bench for psi_generator: per-cycle expected outputs queued from a period model.
module tb_psi_generator;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] divLoad;
  logic       psi;
  logic [7:0] curDiv;
  logic       periodDone;
  logic [7:0] periodCount;
  logic       busy;

  typedef struct packed {
    logic       psi;
    logic       done;
    logic       busy;
    logic [7:0] cur;
    logic [7:0] pc;
  } exp_t;

  typedef struct {
    logic [7:0] div;
    int         half;
    int         periods;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[5];
  int   checks;
  int   passes;

  psi_generator #(.DIV_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .divLoad     (divLoad),
    .psi         (psi),
    .curDiv      (curDiv),
    .periodDone  (periodDone),
    .periodCount (periodCount),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic p, input logic d, input logic b, input logic [7:0] c, input logic [7:0] n);
    exp_t e;
    e.psi  = p;
    e.done = d;
    e.busy = b;
    e.cur  = c;
    e.pc   = n;
    exp_q.push_back(e);
  endtask

  task automatic push_period(input logic [7:0] d, input int half, input logic [7:0] n);
    for (int i = 0; i < half; i++) push(1'b1, 1'b0, 1'b1, d, n);
    for (int i = 0; i < half; i++) push(1'b0, (i == half - 1), 1'b1, d, n);
  endtask

  task automatic check_cycle(input string name);
    exp_t e;
    exp_t a;
    step();
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty at t=%0t", name, $time);
    end else begin
      e = exp_q.pop_front();
      a.psi  = psi;
      a.done = periodDone;
      a.busy = busy;
      a.cur  = curDiv;
      a.pc   = periodCount;
      if (a === e) begin
        passes++;
      end else begin
        $display("FAIL %s t=%0t: got psi=%0b done=%0b busy=%0b cur=%0d cnt=%0d, required psi=%0b done=%0b busy=%0b cur=%0d cnt=%0d",
                 name, $time, a.psi, a.done, a.busy, a.cur, a.pc, e.psi, e.done, e.busy, e.cur, e.pc);
      end
    end
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) check_cycle(name);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en = 1'b0;
    divLoad = 8'd0;
    exp_q.delete();
    push(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    check_cycle("reset");
    rst = 1'b1;
    push(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    check_cycle("idle");
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b0;
    en = 1'b0;
    divLoad = 8'd0;

    tbl[0] = '{div: 8'd250, half: 6,   periods: 3};
    tbl[1] = '{div: 8'd252, half: 4,   periods: 3};
    tbl[2] = '{div: 8'd255, half: 1,   periods: 258};
    tbl[3] = '{div: 8'd0,   half: 256, periods: 2};
    tbl[4] = '{div: 8'd128, half: 128, periods: 2};

    // Steady-state periods for each divider, including count wrap at 255.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      en = 1'b1;
      divLoad = tbl[v].div;
      for (int p = 0; p < tbl[v].periods; p++) push_period(tbl[v].div, tbl[v].half, 8'(p));
      drain($sformatf("vec%0d", v));
    end

    // Divider changed mid-HIGH only takes effect at the next psi rise.
    do_reset();
    en = 1'b1;
    divLoad = 8'd250;
    push_period(8'd250, 6, 8'd0);
    push_period(8'd252, 4, 8'd1);
    for (int i = 0; i < 3; i++) check_cycle("div_change");
    divLoad = 8'd252;
    drain("div_change");

    // Graceful stop: en dropped inside LOW of period 3.
    do_reset();
    en = 1'b1;
    divLoad = 8'd250;
    for (int p = 0; p < 3; p++) push_period(8'd250, 6, 8'(p));
    for (int i = 0; i < 32; i++) check_cycle("en_drop");
    en = 1'b0;
    drain("en_drop");
    push(1'b0, 1'b0, 1'b0, 8'd250, 8'd3);
    push(1'b0, 1'b0, 1'b0, 8'd250, 8'd3);
    drain("en_drop_idle");
    en = 1'b1;
    push(1'b1, 1'b0, 1'b1, 8'd250, 8'd3);
    check_cycle("en_restart");

    // Reset mid-HIGH with en held, then restart on release.
    do_reset();
    en = 1'b1;
    divLoad = 8'd250;
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 1'b1, 8'd250, 8'd0);
    drain("pre_rst");
    rst = 1'b0;
    push(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    push(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    drain("mid_rst");
    rst = 1'b1;
    push_period(8'd250, 6, 8'd0);
    drain("post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
